dmem_mmio_bridge: RTL and testbench
===================================

Name: dmem_mmio_bridge

Overview:
- Sits directly downstream of the processor's dmem port (address_dmem, data, wren → q_dmem).
- Decodes each word address and routes the access to one of two targets:
  - the external data RAM, or
  - a small bank of memory-mapped peripheral registers: LED latch, free-running timer with compare flag, UART transmitter with TX FIFO.
- Returns read data to the processor within the same M-stage cycle.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8: UART TX FIFO entries; must be a power of 2, range 2..64.
- RAM_ADDR_BITS, 12: width of the RAM word address.

Ports:
- clock  in  1  master clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- address_dmem  in  32  word address from the processor M stage.
- data  in  32  store data from the processor.
- wren  in  1  store enable from the processor.
- q_dmem  out  32  load data to the processor.
- ram_address  out  RAM_ADDR_BITS  equals address_dmem[RAM_ADDR_BITS-1:0].
- ram_data  out  32  equals data.
- ram_wren  out  1  wren gated by RAM select.
- ram_q  in  32  RAM read data, valid in the same cycle as ram_address.
- led  out  16  LED latch.
- uart_tx  out  1  serial line, idle high.
- timer_irq  out  1  equals the timer match flag.

Behaviour:
- Decode (combinational):
  - MMIO select: address_dmem[31:16]==16'hFFFF.
  - RAM select: address_dmem[31:RAM_ADDR_BITS]==0.
  - Any other address: read 0, write ignored.
- q_dmem (combinational, no added latency):
  - RAM select → ram_q.
  - MMIO select → register mux.
  - Unmapped MMIO offsets read 0.
- MMIO map, offset = address_dmem[3:0] within 0xFFFFFFF0..0xFFFFFFFF:
  - 0x0 LED: RW; data[15:0]; upper bits read 0.
  - 0x1 TIMER_CNT: RW; increments by 1 every cycle and wraps 0xFFFFFFFF→0. A write loads data and wins over the increment that cycle; the next cycle continues from the loaded value +1.
  - 0x2 TIMER_CMP: RW; 32 bits.
  - 0x3 TIMER_STAT: bit0 = match flag.
    - Set on the edge following any cycle with TIMER_CNT==TIMER_CMP.
    - Write-1-to-clear; a set and a clear in the same cycle → set wins.
  - 0x4 UART_TX: write-only (reads 0); a write pushes data[7:0] into the FIFO.
  - 0x5 UART_STAT: read-only.
    - bit0 full, bit1 empty, bit2 serializer busy.
    - bit3 overflow sticky; cleared by writing 1 to bit3 at offset 0x5.
    - bits[14:8] FIFO count.
- FIFO:
  - Circular buffer with read/write pointers plus a count register (0..FIFO_DEPTH).
  - A push is accepted when count<FIFO_DEPTH, or when count==FIFO_DEPTH with a simultaneous pop.
  - A push that is not accepted is dropped and sets overflow.
  - Simultaneous push and pop leaves count unchanged.
- UART serializer FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into the shift register and enter START on the next edge.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; 3-bit bit index.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back frames have exactly 1 IDLE cycle between STOP and the next START.
  - Busy = state≠IDLE.
- Reset values:
  - All outputs: led=0, uart_tx=1, timer_irq=0.
  - State: TIMER_CNT=0, TIMER_CMP=0xFFFFFFFF, flag=0, FIFO empty, overflow=0, FSM IDLE.
  - Reset mid-frame aborts the frame immediately; uart_tx goes high asynchronously.
- ram_wren=wren&RAM select; an MMIO store never reaches the RAM.

Decomposition:
- Shared package holds:
  - MMIO base (16'hFFFF) and offset constants.
  - UART FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - UART_STAT bit positions.
- One sub-module, uart_tx_fifo_serializer: FIFO plus FSM, with push/byte in, and full, empty, busy, count and uart_tx out.
- Bridge top holds the decode, LED, timer and overflow logic.

Test Plan:
- RAM path: store 0x12345678 to address 5, then load address 5 → ram_wren=1 only on the store; q_dmem=0x12345678; led unchanged.
- LED/unmapped: store 0xABCD1234 to 0xFFFFFFF0 → led=0x1234, ram_wren=0; load 0xFFFFFFF0 → 0x00001234; load 0xFFFFFFFA → 0; load 0x00100000 → 0.
- Timer:
  - Store 10 to TIMER_CMP, then 0 to TIMER_CNT; timer_irq rises exactly 11 edges after the CNT write.
  - Store 1 to TIMER_STAT in the same cycle CNT==CMP after reloading → flag stays 1.
  - A later clear → 0.
- UART frame (CLKS_PER_BIT=4): store 0x55 to UART_TX → uart_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), high for 4; busy for 40 cycles total.
- FIFO full (FIFO_DEPTH=8): 10 back-to-back pushes while the serializer is mid-frame → count=8, full=1, overflow=1; exactly 9 bytes are transmitted in order (one popped in IDLE); write 0x8 to UART_STAT → overflow=0.
- Reset mid-frame: assert reset during DATA → uart_tx=1, empty=1, busy=0 immediately; TIMER_CNT reads 0 after deassert.

Source files
------------

// File: rtl/dmem_mmio_bridge_pkg.sv
// Shared constants for the dmem/MMIO bridge: address map, UART FSM encoding,
// UART status bit layout and the status-word packing helper.
package dmem_mmio_bridge_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFFFF;

  localparam logic [3:0] OFF_LED        = 4'h0;
  localparam logic [3:0] OFF_TIMER_CNT  = 4'h1;
  localparam logic [3:0] OFF_TIMER_CMP  = 4'h2;
  localparam logic [3:0] OFF_TIMER_STAT = 4'h3;
  localparam logic [3:0] OFF_UART_TX    = 4'h4;
  localparam logic [3:0] OFF_UART_STAT  = 4'h5;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int COUNT_W        = 7;

  function automatic logic [31:0] uart_stat_word(input logic full, input logic empty,
                                                 input logic busy, input logic ovf,
                                                 input logic [COUNT_W-1:0] count);
    logic [31:0] w;
    w = 32'd0;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    w[STAT_COUNT_LSB +: COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/dmem_mmio_bridge_uart_tx_fifo_serializer.sv
// UART transmit path: circular byte FIFO feeding an 8N1 serializer FSM.
// The FSM pops the FIFO head while idle and starts the frame on the next edge.
module uart_tx_fifo_serializer
  import dmem_mmio_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         push_byte,
  output logic               full,
  output logic               empty,
  output logic               busy,
  output logic [COUNT_W-1:0] count,
  output logic               uart_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic [7:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [COUNT_W-1:0] count_r;
  uart_state_e        state_r, state_next_s;
  logic [15:0]        clk_cnt_r;
  logic [2:0]         bit_idx_r;
  logic [7:0]         shift_r;
  logic               pop_s, push_ok_s, bit_end_s;

  assign pop_s     = (state_r == UART_IDLE) && (count_r != '0);
  assign push_ok_s = push && ((count_r < DEPTH_C) || pop_s);
  assign bit_end_s = (clk_cnt_r == BIT_LAST);

  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == '0);
  assign busy  = (state_r != UART_IDLE);
  assign count = count_r;

  // FIFO storage (no reset needed; guarded by count)
  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_byte;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)     rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register plus bit timing and shift data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= UART_IDLE;
      clk_cnt_r <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if (state_r == UART_IDLE) begin
        clk_cnt_r <= 16'd0;
        bit_idx_r <= 3'd0;
        if (pop_s) shift_r <= mem_r[rd_ptr_r];
      end else if (bit_end_s) begin
        clk_cnt_r <= 16'd0;
        if (state_r == UART_DATA) bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        clk_cnt_r <= clk_cnt_r + 16'd1;
      end
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      UART_IDLE:  if (pop_s) state_next_s = UART_START;
      UART_START: if (bit_end_s) state_next_s = UART_DATA;
      UART_DATA:  if (bit_end_s && (bit_idx_r == 3'd7)) state_next_s = UART_STOP;
      UART_STOP:  if (bit_end_s) state_next_s = UART_IDLE;
      default:    state_next_s = UART_IDLE;
    endcase
  end

  // FSM outputs; decoded from state so reset forces the line high at once
  always_comb begin
    uart_tx = 1'b1;
    case (state_r)
      UART_START: uart_tx = 1'b0;
      UART_DATA:  uart_tx = shift_r[bit_idx_r];
      default:    uart_tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Processor dmem bridge: decodes word addresses to external RAM or to the
// MMIO bank (LED latch, timer with compare flag, UART transmitter).
module dmem_mmio_bridge
  import dmem_mmio_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int RAM_ADDR_BITS = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              address_dmem,
  input  logic [31:0]              data,
  input  logic                     wren,
  output logic [31:0]              q_dmem,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  output logic [31:0]              ram_data,
  output logic                     ram_wren,
  input  logic [31:0]              ram_q,
  output logic [15:0]              led,
  output logic                     uart_tx,
  output logic                     timer_irq
);

  logic               mmio_sel_s, ram_sel_s, mmio_wr_s;
  logic [3:0]         offset_s;
  logic [15:0]        led_r;
  logic [31:0]        cnt_r, cmp_r;
  logic               flag_r, ovf_r;
  logic               uart_push_s, dropped_s;
  logic               fifo_full_s, fifo_empty_s, uart_busy_s;
  logic [COUNT_W-1:0] fifo_count_s;

  assign mmio_sel_s = (address_dmem[31:16] == MMIO_BASE);
  assign ram_sel_s  = (address_dmem[31:RAM_ADDR_BITS] == '0);
  assign offset_s   = address_dmem[3:0];
  assign mmio_wr_s  = wren && mmio_sel_s;

  assign ram_address = address_dmem[RAM_ADDR_BITS-1:0];
  assign ram_data    = data;
  assign ram_wren    = wren && ram_sel_s;

  assign uart_push_s = mmio_wr_s && (offset_s == OFF_UART_TX);
  // A full FIFO only makes room when the serializer is idle and pops this cycle.
  assign dropped_s   = uart_push_s && fifo_full_s && uart_busy_s;

  assign led       = led_r;
  assign timer_irq = flag_r;

  // LED latch, timer counter/compare/flag and UART overflow sticky bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_r  <= 16'd0;
      cnt_r  <= 32'd0;
      cmp_r  <= 32'hFFFF_FFFF;
      flag_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (mmio_wr_s && (offset_s == OFF_LED)) led_r <= data[15:0];
      if (mmio_wr_s && (offset_s == OFF_TIMER_CNT)) cnt_r <= data;
      else cnt_r <= cnt_r + 32'd1;
      if (mmio_wr_s && (offset_s == OFF_TIMER_CMP)) cmp_r <= data;
      if (cnt_r == cmp_r) flag_r <= 1'b1;
      else if (mmio_wr_s && (offset_s == OFF_TIMER_STAT) && data[0]) flag_r <= 1'b0;
      if (dropped_s) ovf_r <= 1'b1;
      else if (mmio_wr_s && (offset_s == OFF_UART_STAT) && data[STAT_OVF]) ovf_r <= 1'b0;
    end
  end

  // Load data mux, zero for anything unmapped
  always_comb begin
    q_dmem = 32'd0;
    if (ram_sel_s) begin
      q_dmem = ram_q;
    end else if (mmio_sel_s) begin
      case (offset_s)
        OFF_LED:        q_dmem = {16'd0, led_r};
        OFF_TIMER_CNT:  q_dmem = cnt_r;
        OFF_TIMER_CMP:  q_dmem = cmp_r;
        OFF_TIMER_STAT: q_dmem = {31'd0, flag_r};
        OFF_UART_STAT:  q_dmem = uart_stat_word(fifo_full_s, fifo_empty_s, uart_busy_s,
                                                ovf_r, fifo_count_s);
        default:        q_dmem = 32'd0;
      endcase
    end else begin
      q_dmem = 32'd0;
    end
  end

  uart_tx_fifo_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_uart (
    .clock    (clock),
    .reset    (reset),
    .push     (uart_push_s),
    .push_byte(data[7:0]),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .busy     (uart_busy_s),
    .count    (fifo_count_s),
    .uart_tx  (uart_tx)
  );

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Scoreboard bench for dmem_mmio_bridge: load results and transmitted UART
// bytes are queued by the stimulus and checked by independent monitors.
module tb_dmem_mmio_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int RAB   = 12;

  localparam logic [31:0] A_LED   = 32'hFFFF_FFF0;
  localparam logic [31:0] A_CNT   = 32'hFFFF_FFF1;
  localparam logic [31:0] A_CMP   = 32'hFFFF_FFF2;
  localparam logic [31:0] A_TSTAT = 32'hFFFF_FFF3;
  localparam logic [31:0] A_UTX   = 32'hFFFF_FFF4;
  localparam logic [31:0] A_USTAT = 32'hFFFF_FFF5;

  logic            clock = 1'b0;
  logic            reset;
  logic [31:0]     address_dmem, data, q_dmem, ram_data, ram_q;
  logic            wren, ram_wren, uart_tx, timer_irq;
  logic [RAB-1:0]  ram_address;
  logic [15:0]     led;

  logic [31:0] ram_mem [0:(1<<RAB)-1];

  int checks = 0, failures = 0, cyc = 0, frames_seen = 0;
  logic [31:0] ld_exp_q[$];
  string       ld_name_q[$];
  logic [7:0]  tx_exp_q[$];
  bit          ld_flag = 1'b0, mon_enable = 1'b1;
  logic [31:0] cnt_base = 32'd0;
  int          cnt_cyc = 0;

  dmem_mmio_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .RAM_ADDR_BITS(RAB)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .led(led), .uart_tx(uart_tx), .timer_irq(timer_irq));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) if (ram_wren) ram_mem[ram_address] <= ram_data;
  assign ram_q = ram_mem[ram_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] d);
    address_dmem = addr; data = d; wren = 1'b1;
    #1 check("ram_wren_store", {31'd0, ram_wren}, {31'd0, addr[31:RAB] == '0});
    @(posedge clock); #1;
    wren = 1'b0;
    if (addr == A_CNT) begin cnt_base = d; cnt_cyc = cyc; end
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp, input string name);
    address_dmem = addr; wren = 1'b0;
    ld_exp_q.push_back(exp); ld_name_q.push_back(name);
    ld_flag = 1'b1;
    #1 check("ram_wren_load", {31'd0, ram_wren}, 32'd0);
    @(posedge clock); #1;
    ld_flag = 1'b0;
  endtask

  function automatic logic [31:0] timer_now();
    return cnt_base + 32'(cyc - cnt_cyc);
  endfunction

  task automatic wait_tx_drain(input int bound);
    for (int i = 0; i < bound && tx_exp_q.size() != 0; i++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1 check("tx_drain_left", 32'(tx_exp_q.size()), 32'd0);
  endtask

  // Load monitor: compares q_dmem whenever a load is presented
  always @(negedge clock) begin
    if (ld_flag) begin
      if (ld_exp_q.size() == 0) check("load_no_expect", q_dmem, 32'hDEAD_BEEF);
      else check(ld_name_q.pop_front(), q_dmem, ld_exp_q.pop_front());
    end
  end

  // UART monitor: decodes 8N1 frames mid-bit and pops the expected byte
  initial begin
    logic [7:0] got;
    logic       stop_b;
    forever begin
      @(negedge clock);
      if (mon_enable && !reset && uart_tx == 1'b0) begin
        repeat (CPB/2) @(negedge clock);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clock);
          got[b] = uart_tx;
        end
        repeat (CPB) @(negedge clock);
        stop_b = uart_tx;
        frames_seen++;
        check("uart_stop_bit", {31'd0, stop_b}, 32'd1);
        if (tx_exp_q.size() == 0) check("uart_unexpected_frame", {24'd0, got}, 32'hFFFF_FFFF);
        else check("uart_byte", {24'd0, got}, {24'd0, tx_exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_led;
    logic [31:0] exp_ram [int];
    int          ram_addrs[$];
    logic [31:0] a, d, exp_cmp;
    logic [7:0]  b55;
    int          busy_cycles, frames_exp;

    reset = 1'b1; wren = 1'b0; address_dmem = 32'd0; data = 32'd0;
    #2;
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    address_dmem = A_CMP;   #1 check("rst_cmp", q_dmem, 32'hFFFF_FFFF);
    address_dmem = A_USTAT; #1 check("rst_ustat", q_dmem, 32'h0000_0002);
    address_dmem = A_CNT;   #1 check("rst_cnt", q_dmem, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // RAM path and LED/unmapped decode
    store(32'd5, 32'h1234_5678);
    exp_ram[5] = 32'h1234_5678; ram_addrs.push_back(5);
    load(32'd5, 32'h1234_5678, "ram_load5");
    check("led_after_ram", {16'd0, led}, 32'd0);
    store(A_LED, 32'hABCD_1234);
    check("led_write", {16'd0, led}, 32'h0000_1234);
    exp_led = 16'h1234;
    load(A_LED, 32'h0000_1234, "led_read");
    load(32'hFFFF_FFFA, 32'd0, "mmio_unmapped");
    load(32'h0010_0000, 32'd0, "unmapped_read");

    // Randomized mixed traffic against the reference model
    store(A_CNT, $urandom_range(0, 1 << 20));
    exp_cmp = 32'hFFFF_FFFF;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 6))
        0: begin
          a = $urandom_range(0, (1 << RAB) - 1); d = $urandom;
          store(a, d); exp_ram[int'(a)] = d; ram_addrs.push_back(int'(a));
        end
        1: begin
          a = 32'(ram_addrs[$urandom_range(0, ram_addrs.size() - 1)]);
          load(a, exp_ram[int'(a)], "rand_ram_load");
        end
        2: begin
          d = $urandom; store(A_LED, d); exp_led = d[15:0];
          check("rand_led_out", {16'd0, led}, {16'd0, exp_led});
        end
        3: load(A_LED, {16'd0, exp_led}, "rand_led_read");
        4: begin
          a = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
          if (it % 2 == 0) load(a, 32'd0, "rand_unmapped_read");
          else store(a, $urandom);
        end
        5: begin
          load(A_CNT, timer_now(), "rand_timer_cnt");
        end
        default: begin
          exp_cmp = {1'b1, 31'($urandom)};
          store(A_CMP, exp_cmp);
          load(A_CMP, exp_cmp, "rand_timer_cmp");
          load({28'hFFFF_FFF, 4'($urandom_range(6, 15))}, 32'd0, "rand_mmio_hole");
        end
      endcase
    end
    check("led_hold_after_rand", {16'd0, led}, {16'd0, exp_led});

    // Timer compare: flag rises 11 edges after reloading CNT with CMP=10
    check("irq_before_timer", {31'd0, timer_irq}, 32'd0);
    store(A_CMP, 32'd10);
    store(A_CNT, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); @(negedge clock);
      check($sformatf("irq_edge%0d", k), {31'd0, timer_irq}, {31'd0, k >= 11});
    end
    @(posedge clock); #1;
    store(A_TSTAT, 32'd1);
    check("irq_cleared1", {31'd0, timer_irq}, 32'd0);
    store(A_CNT, 32'd5);
    repeat (5) @(posedge clock);
    #1 store(A_TSTAT, 32'd1);
    check("irq_set_wins", {31'd0, timer_irq}, 32'd1);
    store(A_TSTAT, 32'd1);
    check("irq_cleared2", {31'd0, timer_irq}, 32'd0);
    load(A_TSTAT, 32'd0, "tstat_read");

    // Single 0x55 frame, cycle-exact waveform and busy duration
    b55 = 8'h55;
    tx_exp_q.push_back(b55);
    frames_exp = 1;
    store(A_UTX, 32'h0000_0055);
    address_dmem = A_USTAT;
    busy_cycles = 0;
    for (int i = 0; i < 42; i++) begin
      @(negedge clock);
      if (i == 0 || i > 36) check("tx_wave_idle_stop", {31'd0, uart_tx}, 32'd1);
      else if (i <= 4) check("tx_wave_start", {31'd0, uart_tx}, 32'd0);
      else check("tx_wave_data", {31'd0, uart_tx}, {31'd0, b55[(i - 5) / 4]});
      busy_cycles += int'(q_dmem[2]);
    end
    check("busy_cycles", 32'(busy_cycles), 32'd40);
    @(posedge clock); #1;
    wait_tx_drain(100);

    // FIFO overflow: one byte in flight, then 10 pushes into an 8-deep FIFO
    d = $urandom;
    tx_exp_q.push_back(d[7:0]);
    store(A_UTX, d);
    repeat (3) @(posedge clock);
    #1;
    for (int p = 0; p < 10; p++) begin
      d = $urandom;
      if (p < DEPTH) tx_exp_q.push_back(d[7:0]);
      store(A_UTX, d);
    end
    frames_exp += 1 + DEPTH;
    load(A_USTAT, 32'h0000_080D, "ustat_full_ovf");
    store(A_USTAT, 32'h0000_0008);
    load(A_USTAT, 32'h0000_0805, "ustat_ovf_cleared");
    wait_tx_drain(12 * 45);
    repeat (60) @(posedge clock);
    #1 check("frames_seen", 32'(frames_seen), 32'(frames_exp));
    load(A_USTAT, 32'h0000_0002, "ustat_drained");

    // Asynchronous reset in the middle of a frame
    mon_enable = 1'b0;
    store(A_UTX, 32'h0000_00A5);
    repeat (12) @(posedge clock);
    #1 address_dmem = A_USTAT; reset = 1'b1;
    #1 check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("midrst_ustat", q_dmem, 32'h0000_0002);
    check("midrst_led", {16'd0, led}, 32'd0);
    address_dmem = A_CNT; reset = 1'b0;
    #1 check("midrst_cnt", q_dmem, 32'd0);
    @(posedge clock); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
